motor_step_scheduler: RTL and testbench

- Shares the single 4-phase stepper on GPIO_1 between two platform-stage requesters, A and B.
- Each requester issues a move command: direction plus step count.
- Arbitration is round-robin. The block latches the winning command, sequences the coil phases at a fixed step period, holds a settle interval, de-energises the coils, and returns a one-cycle done pulse to the granted requester.
- It replaces ad-hoc per-stage motor_on/p3_on chaining with a single handshake point.

---
 rtl/motor_step_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_motor_step_scheduler.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_scheduler.sv
// motor_step_scheduler
// Round-robin owner of the single 4-phase stepper on GPIO_1. Two requesters
// (A and B) post direction + step count; the winner's command is latched,
// the coils are sequenced one full step every STEP_DIV cycles, the last
// pattern is held for SETTLE_CYCLES, then the coils are released and the
// owner receives a one-cycle done pulse. The phase index survives between
// moves so the rotor position is never lost.

module motor_step_scheduler #(
    parameter int STEP_DIV      = 97_656,
    parameter int SETTLE_CYCLES = 50_000,
    parameter int STEP_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              dir_a,
    input  logic [STEP_W-1:0] steps_a,
    input  logic              req_b,
    input  logic              dir_b,
    input  logic [STEP_W-1:0] steps_b,
    input  logic              abort,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic              aborted,
    output logic              busy,
    output logic [3:0]        GPIO_1
);

    // One shared down-counter serves both the step period and the settle
    // interval, so it is as wide as the larger of the two reload values.
    localparam int STEP_TW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SETTLE_TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TIMER_W   = (STEP_TW > SETTLE_TW) ? STEP_TW : SETTLE_TW;

    localparam logic [TIMER_W-1:0] STEP_RELOAD   = TIMER_W'(STEP_DIV - 1);
    localparam logic [TIMER_W-1:0] SETTLE_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STEP,
        SETTLE,
        DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [1:0]          phaseIdx_q, phaseIdx_d;
    logic [3:0]          gpio_q,     gpio_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic [STEP_W-1:0]   remain_q,   remain_d;
    logic                dir_q,      dir_d;
    logic                owner_q,    owner_d;
    logic                ptr_q,      ptr_d;
    logic                gntA_q,     gntA_d;
    logic                gntB_q,     gntB_d;
    logic                doneA_q,    doneA_d;
    logic                doneB_q,    doneB_d;
    logic                aborted_q,  aborted_d;

    logic                finish;
    logic                finishAbort;
    logic                grantA;
    logic                grantB;

    // Forward walks the table upward, reverse walks it downward; the 2-bit
    // index wraps naturally in both directions.
    function automatic logic [1:0] nextPhase(input logic [1:0] idx, input logic fwd);
        nextPhase = fwd ? (idx + 2'd1) : (idx - 2'd1);
    endfunction

    // Coil pattern for a phase index: 0001, 0010, 0100, 1000.
    function automatic logic [3:0] phasePattern(input logic [1:0] idx);
        phasePattern = 4'b0001 << idx;
    endfunction

    // Arbitration: a lone requester always wins; on a tie the pointer decides
    // (ptr_q = 0 prefers A, 1 prefers B).
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (req_a && (!req_b || !ptr_q)) begin
            grantA = 1'b1;
        end else if (req_b) begin
            grantB = 1'b1;
        end
    end

    // Next-state and output decode; every exit to DONE funnels through
    // finish so the done/aborted pulse and coil release are set in one place.
    always_comb begin
        state_d     = state_q;
        phaseIdx_d  = phaseIdx_q;
        gpio_d      = gpio_q;
        timer_d     = timer_q;
        remain_d    = remain_q;
        dir_d       = dir_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gntA_d      = gntA_q;
        gntB_d      = gntB_q;
        doneA_d     = 1'b0;
        doneB_d     = 1'b0;
        aborted_d   = 1'b0;
        finish      = 1'b0;
        finishAbort = 1'b0;

        unique case (state_q)
            IDLE: begin
                gpio_d = 4'b0000;
                if (grantA) begin
                    owner_d  = 1'b0;
                    gntA_d   = 1'b1;
                    dir_d    = dir_a;
                    remain_d = steps_a;
                    state_d  = GRANT;
                end else if (grantB) begin
                    owner_d  = 1'b1;
                    gntB_d   = 1'b1;
                    dir_d    = dir_b;
                    remain_d = steps_b;
                    state_d  = GRANT;
                end
            end

            GRANT: begin
                if (abort) begin
                    finish      = 1'b1;
                    finishAbort = 1'b1;
                end else if (remain_q == '0) begin
                    finish = 1'b1;
                end else begin
                    phaseIdx_d = nextPhase(phaseIdx_q, dir_q);
                    gpio_d     = phasePattern(nextPhase(phaseIdx_q, dir_q));
                    timer_d    = STEP_RELOAD;
                    state_d    = STEP;
                end
            end

            STEP: begin
                if (abort) begin
                    finish      = 1'b1;
                    finishAbort = 1'b1;
                end else if (timer_q == '0) begin
                    if (remain_q > STEP_W'(1)) begin
                        remain_d   = remain_q - STEP_W'(1);
                        phaseIdx_d = nextPhase(phaseIdx_q, dir_q);
                        gpio_d     = phasePattern(nextPhase(phaseIdx_q, dir_q));
                        timer_d    = STEP_RELOAD;
                    end else begin
                        remain_d = '0;
                        timer_d  = SETTLE_RELOAD;
                        state_d  = SETTLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            SETTLE: begin
                if (abort) begin
                    finish      = 1'b1;
                    finishAbort = 1'b1;
                end else if (timer_q == '0) begin
                    finish = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            DONE: begin
                gpio_d  = 4'b0000;
                gntA_d  = 1'b0;
                gntB_d  = 1'b0;
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end

            default: begin
                gpio_d  = 4'b0000;
                gntA_d  = 1'b0;
                gntB_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d   = DONE;
            gpio_d    = 4'b0000;
            doneA_d   = ~owner_q;
            doneB_d   = owner_q;
            aborted_d = finishAbort;
        end
    end

    // State and output registers; reset releases the coils at once and
    // returns the phase index and round-robin pointer to their home values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phaseIdx_q <= 2'd0;
            gpio_q     <= 4'b0000;
            timer_q    <= '0;
            remain_q   <= '0;
            dir_q      <= 1'b0;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            gntA_q     <= 1'b0;
            gntB_q     <= 1'b0;
            doneA_q    <= 1'b0;
            doneB_q    <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phaseIdx_q <= phaseIdx_d;
            gpio_q     <= gpio_d;
            timer_q    <= timer_d;
            remain_q   <= remain_d;
            dir_q      <= dir_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            gntA_q     <= gntA_d;
            gntB_q     <= gntB_d;
            doneA_q    <= doneA_d;
            doneB_q    <= doneB_d;
            aborted_q  <= aborted_d;
        end
    end

    assign gnt_a   = gntA_q;
    assign gnt_b   = gntB_q;
    assign done_a  = doneA_q;
    assign done_b  = doneB_q;
    assign aborted = aborted_q;
    assign busy    = (state_q != IDLE);
    assign GPIO_1  = gpio_q;

    // Structural invariants: exclusive ownership, exclusive completion, and a
    // coil drive that is never more than one-hot.
    gntMutex:  assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
    doneMutex: assert property (@(posedge clk) disable iff (!rst_n) !(done_a && done_b));
    coilSafe:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(GPIO_1));

endmodule

// File: tb/tb_motor_step_scheduler.sv
// Directed testbench for motor_step_scheduler with a short step period and
// settle interval so whole moves fit in a few dozen cycles.

module tb_motor_step_scheduler;

    localparam int STEP_DIV      = 4;
    localparam int SETTLE_CYCLES = 3;
    localparam int STEP_W        = 8;

    logic              clk;
    logic              rst_n;
    logic              req_a;
    logic              dir_a;
    logic [STEP_W-1:0] steps_a;
    logic              req_b;
    logic              dir_b;
    logic [STEP_W-1:0] steps_b;
    logic              abort;
    logic              gnt_a;
    logic              gnt_b;
    logic              done_a;
    logic              done_b;
    logic              aborted;
    logic              busy;
    logic [3:0]        GPIO_1;

    int vectors    = 0;
    int miscompares = 0;

    motor_step_scheduler #(
        .STEP_DIV      (STEP_DIV),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .STEP_W        (STEP_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .dir_a   (dir_a),
        .steps_a (steps_a),
        .req_b   (req_b),
        .dir_b   (dir_b),
        .steps_b (steps_b),
        .abort   (abort),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .aborted (aborted),
        .busy    (busy),
        .GPIO_1  (GPIO_1)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one clock and settle just past the edge before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({gnt_a, gnt_b, done_a, done_b, aborted, busy, GPIO_1} !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {gnt_a, gnt_b, done_a, done_b, aborted, busy, GPIO_1}, 10'b0);
        end
        rst_n = 1'b1;
    endtask

    // A forward 3 steps from phase 0; command inputs are scrambled after grant.
    task automatic test_forward_move();
        logic [3:0] e;
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd3;
        tick();
        vectors++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || busy !== 1'b1 || GPIO_1 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL fwd_grant: got gnt_a=%b gnt_b=%b busy=%b gpio=%b expected 1 0 1 0000",
                     gnt_a, gnt_b, busy, GPIO_1);
        end
        req_a = 1'b0; dir_a = 1'b0; steps_a = 8'hFF;
        tick();
        for (int i = 0; i < 15; i++) begin
            e = (i < 4) ? 4'b0010 : (i < 8) ? 4'b0100 : 4'b1000;
            vectors++;
            if (GPIO_1 !== e || done_a !== 1'b0 || gnt_a !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fwd_pattern[%0d]: got gpio=%b done_a=%b gnt_a=%b expected %b 0 1",
                         i, GPIO_1, done_a, gnt_a, e);
            end
            tick();
        end
        vectors++;
        if (GPIO_1 !== 4'b0000 || done_a !== 1'b1 || done_b !== 1'b0 || aborted !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fwd_done: got gpio=%b done_a=%b done_b=%b aborted=%b busy=%b expected 0000 1 0 0 1",
                     GPIO_1, done_a, done_b, aborted, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || gnt_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fwd_idle: got busy=%b gnt_a=%b done_a=%b expected 0 0 0", busy, gnt_a, done_a);
        end
    endtask

    // B reverse 5 steps from phase 3, wrapping through 0 back to 3.
    task automatic test_reverse_wrap();
        logic [3:0] seq [5];
        logic [3:0] e;
        seq[0] = 4'b0100; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b1000; seq[4] = 4'b0100;
        req_b = 1'b1; dir_b = 1'b0; steps_b = 8'd5;
        tick();
        vectors++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rev_grant: got gnt_a=%b gnt_b=%b expected 0 1", gnt_a, gnt_b);
        end
        req_b = 1'b0;
        tick();
        for (int i = 0; i < 23; i++) begin
            e = (i < 20) ? seq[i / 4] : 4'b0100;
            vectors++;
            if (GPIO_1 !== e || done_b !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rev_pattern[%0d]: got gpio=%b done_b=%b expected %b 0", i, GPIO_1, done_b, e);
            end
            tick();
        end
        vectors++;
        if (GPIO_1 !== 4'b0000 || done_b !== 1'b1 || done_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rev_done: got gpio=%b done_b=%b done_a=%b expected 0000 1 0", GPIO_1, done_b, done_a);
        end
        tick();
        vectors++;
        if (done_b !== 1'b0 || busy !== 1'b0 || gnt_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rev_idle: got done_b=%b busy=%b gnt_b=%b expected 0 0 0", done_b, busy, gnt_b);
        end
    endtask

    // Both requesters held continuously: grants alternate A, B, A.
    task automatic test_round_robin();
        logic [1:0] order [3];
        int   grants;
        int   overlap;
        logic prevA, prevB;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        req_b = 1'b1; dir_b = 1'b1; steps_b = 8'd1;
        grants = 0; overlap = 0; prevA = 1'b0; prevB = 1'b0;
        for (int c = 0; c < 60 && grants < 3; c++) begin
            tick();
            if (gnt_a && gnt_b) overlap++;
            if (gnt_a && !prevA) begin order[grants] = 2'd1; grants++; end
            else if (gnt_b && !prevB) begin order[grants] = 2'd2; grants++; end
            prevA = gnt_a;
            prevB = gnt_b;
        end
        req_a = 1'b0; req_b = 1'b0;
        vectors++;
        if (grants !== 3) begin
            miscompares++;
            $display("[TB] FAIL rr_grant_count: got %0d expected 3 within budget", grants);
        end else begin
            vectors++;
            if (order[0] !== 2'd1 || order[1] !== 2'd2 || order[2] !== 2'd1) begin
                miscompares++;
                $display("[TB] FAIL rr_order: got %0d,%0d,%0d expected 1,2,1 (1=A 2=B)",
                         order[0], order[1], order[2]);
            end
        end
        for (int c = 0; c < 40 && busy; c++) begin
            tick();
            if (gnt_a && gnt_b) overlap++;
        end
        vectors++;
        if (overlap !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_overlap_idle: got overlap=%0d busy=%b expected 0 0", overlap, busy);
        end
    endtask

    // Zero-step move: GRANT then DONE, coils stay off, phase index untouched.
    task automatic test_zero_steps();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd0;
        tick();
        req_a = 1'b0;
        vectors++;
        if (gnt_a !== 1'b1 || GPIO_1 !== 4'b0000 || done_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_grant: got gnt_a=%b gpio=%b done_a=%b expected 1 0000 0", gnt_a, GPIO_1, done_a);
        end
        tick();
        vectors++;
        if (gnt_a !== 1'b1 || GPIO_1 !== 4'b0000 || done_a !== 1'b1 || aborted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_done: got gnt_a=%b gpio=%b done_a=%b aborted=%b expected 1 0000 1 0",
                     gnt_a, GPIO_1, done_a, aborted);
        end
        tick();
        vectors++;
        if (gnt_a !== 1'b0 || busy !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_idle: got gnt_a=%b busy=%b done_a=%b expected 0 0 0", gnt_a, busy, done_a);
        end
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        tick();
        req_a = 1'b0;
        tick();
        vectors++;
        if (GPIO_1 !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL zero_phase_kept: got %b expected 0010", GPIO_1);
        end
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (done_a !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_followup_done: got done_a=%b expected 1", done_a);
        end
        tick();
    endtask

    // Abort on the 6th STEP cycle of a 3-step forward move starting at phase 1.
    task automatic test_abort();
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd3;
        tick();
        req_a = 1'b0;
        tick();
        vectors++;
        if (GPIO_1 !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL abort_first: got %b expected 0100", GPIO_1);
        end
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (GPIO_1 !== 4'b1000 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_sixth: got gpio=%b busy=%b expected 1000 1", GPIO_1, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (GPIO_1 !== 4'b0000 || done_a !== 1'b1 || aborted !== 1'b1 || done_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_done: got gpio=%b done_a=%b aborted=%b done_b=%b expected 0000 1 1 0",
                     GPIO_1, done_a, aborted, done_b);
        end
        tick();
        vectors++;
        if (aborted !== 1'b0 || done_a !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got aborted=%b done_a=%b busy=%b expected 0 0 0", aborted, done_a, busy);
        end
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        tick();
        req_a = 1'b0;
        tick();
        vectors++;
        if (GPIO_1 !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL abort_resume_phase: got %b expected 0001", GPIO_1);
        end
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (done_a !== 1'b1 || aborted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_resume_done: got done_a=%b aborted=%b expected 1 0", done_a, aborted);
        end
        tick();
    endtask

    // Reset asserted for one cycle during SETTLE: immediate release, no done.
    task automatic test_reset_mid_move();
        int doneSeen;
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        tick();
        req_a = 1'b0;
        tick();
        vectors++;
        if (GPIO_1 !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL rstmid_first: got %b expected 0010", GPIO_1);
        end
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (GPIO_1 !== 4'b0000 || gnt_a !== 1'b0 || busy !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_release: got gpio=%b gnt_a=%b busy=%b done_a=%b expected 0000 0 0 0",
                     GPIO_1, gnt_a, busy, done_a);
        end
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a || done_b || aborted) doneSeen++;
        end
        vectors++;
        if (doneSeen !== 0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", doneSeen);
        end
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        tick();
        req_a = 1'b0;
        tick();
        vectors++;
        if (GPIO_1 !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL rstmid_restart: got %b expected 0010", GPIO_1);
        end
        for (int i = 0; i < 8; i++) tick();
    endtask

    // Largest step count from phase 1: 255*4 step cycles + 3 settle, ends on 0001.
    task automatic test_max_steps();
        int   energised;
        int   sawDone;
        logic [3:0] lastPat;
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'hFF;
        tick();
        req_a = 1'b0;
        energised = 0; sawDone = 0; lastPat = 4'b0000;
        for (int c = 0; c < 1200; c++) begin
            tick();
            if (done_a) begin
                sawDone = 1;
                break;
            end
            if (GPIO_1 !== 4'b0000) begin
                energised++;
                lastPat = GPIO_1;
            end
        end
        vectors++;
        if (sawDone !== 1 || energised !== 1023) begin
            miscompares++;
            $display("[TB] FAIL max_duration: got done=%0d cycles=%0d expected 1 1023", sawDone, energised);
        end
        vectors++;
        if (lastPat !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL max_final_phase: got %b expected 0001", lastPat);
        end
        tick();
    endtask

    // abort raised while idle must not start or report anything.
    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || aborted !== 1'b0 || done_a !== 1'b0 || done_b !== 1'b0 || GPIO_1 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL abort_in_idle: got busy=%b aborted=%b done=%b%b gpio=%b expected 0 0 00 0000",
                     busy, aborted, done_a, done_b, GPIO_1);
        end
        abort = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; dir_a = 1'b0; steps_a = '0;
        req_b = 1'b0; dir_b = 1'b0; steps_b = '0;
        abort = 1'b0;
        test_reset();
        test_forward_move();
        test_reverse_wrap();
        test_round_robin();
        test_zero_steps();
        test_abort();
        test_reset_mid_move();
        test_max_steps();
        test_abort_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
